reg_file: RTL and testbench

//  Architectural register file plus rename-tag table (x0..x31). Write side of the commit

---
 rtl/reg_file.sv | 168 ++++++++++++++++
 tb/tb_reg_file.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: architectural register file (x0..x31) with rename-tag table.
// Commit side writes retired results from the reorder buffer; rename side
// records which ROB id will produce each register. Two read ports hand the
// issuer either a ready value (q=0) or the producing ROB id.
// Optional build macro: REG_FILE_COMMIT_CNT_EN adds the commit_cnt counter.

// One read port: x0 hardwired, same-cycle commit bypass, else table lookup.
module reg_file_rd_port #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5,
    parameter int ROB_ID_W = 5,
    parameter int NUM_REGS = 32
) (
    input  logic [REG_ID_W-1:0]               rs,
    input  logic [NUM_REGS-1:0][ROB_ID_W-1:0] tags,
    input  logic [NUM_REGS-1:0][XLEN-1:0]     values,
    input  logic [ROB_ID_W-1:0]               dest_from_rob,
    input  logic [REG_ID_W-1:0]               rd_from_rob,
    input  logic [XLEN-1:0]                   value_from_rob,
    output logic [ROB_ID_W-1:0]               q,
    output logic [XLEN-1:0]                   v
);
    logic [ROB_ID_W-1:0] tag_rs;
    logic [XLEN-1:0]     value_rs;
    logic                bypass;

    assign tag_rs   = tags[rs];
    assign value_rs = values[rs];
    // A commit whose id matches the current mapping makes the value ready now.
    assign bypass   = (dest_from_rob != '0) && (rd_from_rob == rs) && (tag_rs == dest_from_rob);

    // Operand select: x0 reads zero, bypass beats the stored mapping.
    always_comb begin
        q = tag_rs;
        v = value_rs;
        if (rs == '0) begin
            q = '0;
            v = '0;
        end else if (bypass) begin
            q = '0;
            v = value_from_rob;
        end
    end
endmodule

module reg_file #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rename_valid_from_issuer,
    input  logic [REG_ID_W-1:0] rd_from_issuer,
    input  logic [ROB_ID_W-1:0] dest_from_issuer,
    input  logic [REG_ID_W-1:0] rs1_from_issuer,
    input  logic [REG_ID_W-1:0] rs2_from_issuer,
    output logic [ROB_ID_W-1:0] qj_to_issuer,
    output logic [XLEN-1:0]     vj_to_issuer,
    output logic [ROB_ID_W-1:0] qk_to_issuer,
    output logic [XLEN-1:0]     vk_to_issuer,
    input  logic [ROB_ID_W-1:0] dest_from_rob,
    input  logic [REG_ID_W-1:0] rd_from_rob,
    input  logic [XLEN-1:0]     value_from_rob,
    input  logic                reset_from_rob_bus
`ifdef REG_FILE_COMMIT_CNT_EN
    ,
    output logic [31:0]         commit_cnt
`endif
);
    localparam int NUM_REGS  = 1 << REG_ID_W;
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic                vld;
        logic [REG_ID_W-1:0] rd;
        logic [ROB_ID_W-1:0] id;
    } wr_req_t;

    logic [NUM_REGS-1:0][XLEN-1:0]     values;
    logic [NUM_REGS-1:0][ROB_ID_W-1:0] tags;

    wr_req_t ren_req;
    wr_req_t cmt_req;
    logic    flush;
    logic    cmt_clr_tag;

    logic [NUM_PORTS-1:0][REG_ID_W-1:0] rs_vec;
    logic [NUM_PORTS-1:0][ROB_ID_W-1:0] q_vec;
    logic [NUM_PORTS-1:0][XLEN-1:0]     v_vec;

    assign flush = reset_from_rob_bus;

    // Qualify rename and commit requests; x0 writes are dropped here.
    always_comb begin
        ren_req.vld = rdy && rename_valid_from_issuer && (rd_from_issuer != '0) && !flush;
        ren_req.rd  = rd_from_issuer;
        ren_req.id  = dest_from_issuer;
        cmt_req.vld = rdy && (dest_from_rob != '0) && (rd_from_rob != '0);
        cmt_req.rd  = rd_from_rob;
        cmt_req.id  = dest_from_rob;
    end

    // Commit only frees the mapping if it is still the youngest one and no
    // rename of the same register lands on this edge.
    assign cmt_clr_tag = cmt_req.vld && (tags[cmt_req.rd] == cmt_req.id) &&
                         !(ren_req.vld && (ren_req.rd == cmt_req.rd));

    // Value array: every committed write lands, even stale ones and during flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            values <= '0;
        end else if (cmt_req.vld) begin
            values[cmt_req.rd] <= value_from_rob;
        end
    end

    // Tag table: flush clears everything, otherwise commit-clear then rename.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
        end else if (flush) begin
            tags <= '0;
        end else begin
            if (cmt_clr_tag)
                tags[cmt_req.rd] <= '0;
            if (ren_req.vld)
                tags[ren_req.rd] <= ren_req.id;
        end
    end

    assign rs_vec[0] = rs1_from_issuer;
    assign rs_vec[1] = rs2_from_issuer;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        reg_file_rd_port #(
            .XLEN     (XLEN),
            .REG_ID_W (REG_ID_W),
            .ROB_ID_W (ROB_ID_W),
            .NUM_REGS (NUM_REGS)
        ) u_port (
            .rs             (rs_vec[p]),
            .tags           (tags),
            .values         (values),
            .dest_from_rob  (dest_from_rob),
            .rd_from_rob    (rd_from_rob),
            .value_from_rob (value_from_rob),
            .q              (q_vec[p]),
            .v              (v_vec[p])
        );
    end

    assign qj_to_issuer = q_vec[0];
    assign vj_to_issuer = v_vec[0];
    assign qk_to_issuer = q_vec[1];
    assign vk_to_issuer = v_vec[1];

`ifdef REG_FILE_COMMIT_CNT_EN
    // Retired-write counter; free-running wrap, flush does not suppress it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            commit_cnt <= '0;
        else if (cmt_req.vld)
            commit_cnt <= commit_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file with a read-result scoreboard.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rename_valid;
    logic [4:0]  rd_iss, dest_iss, rs1, rs2;
    logic [4:0]  qj, qk;
    logic [31:0] vj, vk;
    logic [4:0]  dest_rob, rd_rob;
    logic [31:0] value_rob;
    logic        flush;
`ifdef REG_FILE_COMMIT_CNT_EN
    logic [31:0] commit_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [4:0]  qj;
        logic [31:0] vj;
        logic [4:0]  qk;
        logic [31:0] vk;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_file dut (
        .clk                      (clk),
        .rst                      (rst),
        .rdy                      (rdy),
        .rename_valid_from_issuer (rename_valid),
        .rd_from_issuer           (rd_iss),
        .dest_from_issuer         (dest_iss),
        .rs1_from_issuer          (rs1),
        .rs2_from_issuer          (rs2),
        .qj_to_issuer             (qj),
        .vj_to_issuer             (vj),
        .qk_to_issuer             (qk),
        .vk_to_issuer             (vk),
        .dest_from_rob            (dest_rob),
        .rd_from_rob              (rd_rob),
        .value_from_rob           (value_rob),
        .reset_from_rob_bus       (flush)
`ifdef REG_FILE_COMMIT_CNT_EN
        ,
        .commit_cnt               (commit_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rename_valid = 1'b0; rd_iss = '0; dest_iss = '0;
        dest_rob = '0; rd_rob = '0; value_rob = '0; flush = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] id);
        rename_valid = 1'b1; rd_iss = rd; dest_iss = id;
    endtask

    task automatic commit(input logic [4:0] id, input logic [4:0] rd, input logic [31:0] val);
        dest_rob = id; rd_rob = rd; value_rob = val;
    endtask

    // Drive read indices, queue the expected operands, then sample and compare.
    task automatic chk(input string name, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] eqj, input logic [31:0] evj,
                       input logic [4:0] eqk, input logic [31:0] evk);
        exp_t e;
        rs1 = a; rs2 = b;
        e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_tests++;
        assert ({qj, vj, qk, vk} === {e.qj, e.vj, e.qk, e.vk}) else begin
            n_fail++;
            $error("FAIL %s: got qj=%0d vj=%h qk=%0d vk=%h, expected qj=%0d vj=%h qk=%0d vk=%h",
                   e.name, qj, vj, qk, vk, e.qj, e.vj, e.qk, e.vk);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rs1 = '0; rs2 = '0;
        idle();
        #2;
        chk("reset_x5_x0", 5'd5, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("reset_x31", 5'd31, 5'd1, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        rst = 1'b0;
        step();

        // 1: rename x5->3, invisible same cycle, visible next
        rename(5'd5, 5'd3);
        chk("rename_same_cycle", 5'd5, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
        step(); idle();
        chk("rename_next_cycle", 5'd5, 5'd0, 5'd3, 32'h0, 5'd0, 32'h0);

        // 2: matching commit bypasses on both ports, then clears tag
        commit(5'd3, 5'd5, 32'hDEAD);
        chk("commit_bypass", 5'd5, 5'd5, 5'd0, 32'hDEAD, 5'd0, 32'hDEAD);
        step(); idle();
        chk("commit_written", 5'd5, 5'd0, 5'd0, 32'hDEAD, 5'd0, 32'h0);
        commit(5'd4, 5'd5, 32'h99);
        chk("no_bypass_id_mismatch", 5'd5, 5'd0, 5'd0, 32'hDEAD, 5'd0, 32'h0);
        idle();

        // 3: rename and matching commit on same rd, same edge -> rename wins
        rename(5'd5, 5'd3);
        step(); idle();
        rename(5'd5, 5'd7);
        commit(5'd3, 5'd5, 32'h11);
        step(); idle();
        chk("rename_beats_commit", 5'd5, 5'd0, 5'd7, 32'h11, 5'd0, 32'h0);
        commit(5'd3, 5'd5, 32'h22);
        chk("stale_no_bypass", 5'd5, 5'd0, 5'd7, 32'h11, 5'd0, 32'h0);
        step(); idle();
        chk("stale_commit_keeps_tag", 5'd5, 5'd0, 5'd7, 32'h22, 5'd0, 32'h0);

        // 4: flush with same-cycle commit and rename
        rename(5'd1, 5'd2);
        step(); idle();
        rename(5'd2, 5'd4);
        step(); idle();
        chk("tags_before_flush", 5'd1, 5'd2, 5'd2, 32'h0, 5'd4, 32'h0);
        flush = 1'b1;
        commit(5'd2, 5'd1, 32'h40);
        rename(5'd3, 5'd6);
        step(); idle();
        chk("flush_x1_x3", 5'd1, 5'd3, 5'd0, 32'h40, 5'd0, 32'h0);
        chk("flush_x2_x5", 5'd2, 5'd5, 5'd0, 32'h0, 5'd0, 32'h22);

        // 5: x0 immune to rename and commit
        rename(5'd0, 5'd9);
        step(); idle();
        commit(5'd9, 5'd0, 32'hFF);
        chk("x0_during_commit", 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
        step(); idle();
        chk("x0_after_commit", 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);

        // rdy=0 holds state, but flush still acts
        rdy = 1'b0;
        rename(5'd4, 5'd5);
        step(); idle();
        chk("rdy0_rename_dropped", 5'd4, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
        rdy = 1'b1;
        rename(5'd4, 5'd5);
        step(); idle();
        rdy = 1'b0;
        commit(5'd5, 5'd4, 32'h77);
        step(); idle();
        chk("rdy0_commit_dropped", 5'd4, 5'd0, 5'd5, 32'h0, 5'd0, 32'h0);
        flush = 1'b1;
        step(); idle();
        chk("rdy0_flush_acts", 5'd4, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0);
        rdy = 1'b1;

        // async reset mid-cycle clears everything immediately
        rename(5'd6, 5'd8);
        step(); idle();
        chk("pre_rst_x6", 5'd6, 5'd1, 5'd8, 32'h0, 5'd0, 32'h40);
        #1 rst = 1'b1;
        chk("async_rst", 5'd6, 5'd1, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        rst = 1'b0;
        step();

`ifdef REG_FILE_COMMIT_CNT_EN
        // 6: commit counter, x0 commits excluded, wrap at all-ones
        n_tests++;
        assert (commit_cnt === 32'd0) else begin
            n_fail++; $error("FAIL cnt_reset: got %h expected %h", commit_cnt, 32'd0);
        end
        commit(5'd1, 5'd7, 32'h1); step();
        commit(5'd2, 5'd0, 32'h2); step();
        commit(5'd3, 5'd8, 32'h3); step(); idle();
        n_tests++;
        assert (commit_cnt === 32'd2) else begin
            n_fail++; $error("FAIL cnt_three_commits: got %h expected %h", commit_cnt, 32'd2);
        end
        force dut.commit_cnt = 32'hFFFF_FFFF;
        #1 release dut.commit_cnt;
        commit(5'd4, 5'd9, 32'h4); step(); idle();
        n_tests++;
        assert (commit_cnt === 32'd0) else begin
            n_fail++; $error("FAIL cnt_wrap: got %h expected %h", commit_cnt, 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
